// File: rtl/mem_lsu_if.sv
// Data-memory bus between mem_lsu (master) and the data memory (slave).
// Address phase is req/gnt; read data returns later on rvalid.
interface mem_lsu_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// ME-stage load/store unit: one data-memory access per instruction, stalls the pipe while in flight.
// Define LSU_MISALIGN_EXC_EN to complete misaligned accesses with err_o instead of masking the address.
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        is_load_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    mem_lsu_if.master   dmem,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] ld_data_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr, r_wdata, r_ld;
    logic [3:0]    r_be;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          r_we, r_err;

    logic          w_start, w_abort, w_to, w_req, w_stall, w_cap, w_err_nxt;
    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_ld_fmt;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_start = req_i & (is_load_i | mem_wren_i);

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = st_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_off   = addr_i[1:0];
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                w_off   = {addr_i[1], 1'b0};
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_EXC_EN
    assign w_abort = (funct3_i[1:0] == 2'b01) ? addr_i[0] :
                     ((funct3_i[1:0] != 2'b00) & (addr_i[1:0] != 2'b00));
`else
    assign w_abort = 1'b0;
`endif

    assign w_byte = dmem.dmem_rdata_i[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ld_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_fmt = {24'h0, w_byte};
            3'b001:  w_ld_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_fmt = {16'h0, w_half};
            default: w_ld_fmt = dmem.dmem_rdata_i;
        endcase
    end

    // Counter value k-1 in the k-th REQ/WAIT cycle, so the abort lands after TIMEOUT_CYCLES cycles
    assign w_to = (r_cnt >= CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_cap       = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_start;
                if (w_start) begin
                    w_state_nxt = w_abort ? S_DONE : S_REQ;
                    w_err_nxt   = w_abort;
                end
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dmem.dmem_gnt_i) begin
                    w_state_nxt = r_we ? S_DONE : S_WAIT;
                end else if (w_to) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (dmem.dmem_rvalid_i) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_to) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ld    <= '0;
            r_be    <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (r_state == S_IDLE && w_start) begin
                r_addr  <= {addr_i[31:2], 2'b00};
                r_off   <= w_off;
                r_f3    <= funct3_i;
                r_we    <= mem_wren_i & ~is_load_i;
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != CW'(TIMEOUT_CYCLES))
                r_cnt <= r_cnt + CW'(1);
            if (w_cap)
                r_ld <= w_ld_fmt;
        end
    end

    assign dmem.dmem_req_o   = w_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_be_o    = r_be;
    assign dmem.dmem_wdata_o = r_wdata;
    assign stall_o           = w_stall;
    assign done_o            = (r_state == S_DONE);
    assign err_o             = r_err;
    assign ld_data_o         = r_ld;
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized accesses against a
// behavioural model of byte lanes, load formatting, completion latency and timeout.
module tb_mem_lsu;
    localparam int TO = 12;
`ifdef LSU_MISALIGN_EXC_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0, is_load_i = 1'b0, mem_wren_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, st_data_i = '0;
    logic        stall_o, done_o, err_o;
    logic [31:0] ld_data_o;
    logic [31:0] exp_ld = '0;
    int          n_chk = 0, n_fail = 0;

    mem_lsu_if u_if ();

    mem_lsu #(.TIMEOUT_CYCLES(TO)) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .is_load_i  (is_load_i),
        .mem_wren_i (mem_wren_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .st_data_i  (st_data_i),
        .dmem       (u_if),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .ld_data_o  (ld_data_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        int s;
        s = 4;
        if (f3[1:0] == 2'b00) s = 1;
        else if (f3[1:0] == 2'b01) s = 2;
        return s;
    endfunction

    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        return o - (o % m_size(f3));
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << m_size(f3)) - 1) << m_off(f3, a));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] st);
        if (m_size(f3) == 1) return (st & 32'hFF) * 32'h01010101;
        if (m_size(f3) == 2) return (st & 32'hFFFF) * 32'h00010001;
        return st;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v, span;
        int     sz;
        sz   = m_size(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rd) >> (8 * m_off(f3, a))) % span;
        if (f3 < 3'd4 && sz < 4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        return MIS_EN && ((a % 4) % m_size(f3)) != 0;
    endfunction

    // ---------------- stimulus driver (observes, does not judge) ----------------
    task automatic run_access(input bit ld, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] st, input logic [31:0] rd,
                              input int g, input int r,
                              output int dc, output bit er, output int sb, output bit rq, output bit un,
                              output logic [31:0] oa, output logic [3:0] ob, output logic [31:0] ow,
                              output logic owe, output logic [31:0] old, output logic [2:0] post);
        int nreq, gc;
        dc = -1; er = 0; sb = 0; rq = 0; un = 0;
        oa = '0; ob = '0; ow = '0; owe = 1'b0; old = '0; post = '0;
        nreq = 0; gc = -1;
        @(posedge clk_i); #1;
        req_i = 1'b1; is_load_i = ld; mem_wren_i = wr; funct3_i = f3; addr_i = a; st_data_i = st;
        for (int c = 0; c < TO + 10; c++) begin
            #4;
            if (stall_o !== ~done_o) sb++;
            if (u_if.dmem_req_o === 1'b1) begin
                if (!rq) begin
                    rq = 1; oa = u_if.dmem_addr_o; ob = u_if.dmem_be_o;
                    ow = u_if.dmem_wdata_o; owe = u_if.dmem_we_o;
                end else if ({oa, ob, ow, owe} !== {u_if.dmem_addr_o, u_if.dmem_be_o,
                                                     u_if.dmem_wdata_o, u_if.dmem_we_o}) begin
                    un = 1;
                end
                if (nreq == g) begin u_if.dmem_gnt_i = 1'b1; gc = c; end
                nreq++;
            end
            if (ld && gc >= 0 && r > 0 && c == gc + r) begin
                u_if.dmem_rvalid_i = 1'b1; u_if.dmem_rdata_i = rd;
            end
            if (done_o === 1'b1) begin dc = c; er = err_o; old = ld_data_o; end
            @(posedge clk_i); #1;
            u_if.dmem_gnt_i = 1'b0; u_if.dmem_rvalid_i = 1'b0; u_if.dmem_rdata_i = $urandom;
            if (dc >= 0) break;
        end
        req_i = 1'b0; is_load_i = 1'b0; mem_wren_i = 1'b0;
        #4;
        post = {done_o, stall_o, u_if.dmem_req_o};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_chk++;
        if ({u_if.dmem_req_o, u_if.dmem_we_o, u_if.dmem_addr_o, u_if.dmem_be_o, u_if.dmem_wdata_o,
             stall_o, done_o, err_o, ld_data_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got req=%b stall=%b done=%b err=%b ld=%h want all 0",
                               u_if.dmem_req_o, stall_o, done_o, err_o, ld_data_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_store();
        int dc, sb; bit er, rq, un; logic [31:0] oa, ow, old; logic [3:0] ob; logic owe; logic [2:0] post;
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (dc !== 2 || er !== 1'b0 || sb !== 0) begin
            n_fail++; $display("FAIL sw_timing: got cyc=%0d err=%b stallbad=%0d want cyc=2 err=0 stallbad=0", dc, er, sb);
        end
        n_chk++;
        if ({oa, ob, ow, owe} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
            n_fail++; $display("FAIL sw_bus: got addr=%h be=%b wd=%h we=%b want 100 1111 deadbeef 1", oa, ob, ow, owe);
        end
        n_chk++;
        if (old !== exp_ld || post !== 3'b000) begin
            n_fail++; $display("FAIL sw_after: got ld=%h post=%b want ld=%h post=000", old, post, exp_ld);
        end
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if ({oa, ob, ow} !== {32'h100, 4'b1000, 32'hA5A5A5A5} || dc !== 3 || un !== 1'b0) begin
            n_fail++; $display("FAIL sb_bus: got addr=%h be=%b wd=%h cyc=%0d unstable=%b want 100 1000 a5a5a5a5 3 0",
                               oa, ob, ow, dc, un);
        end
    endtask

    task automatic test_load();
        int dc, sb; bit er, rq, un; logic [31:0] oa, ow, old, rd; logic [3:0] ob; logic owe; logic [2:0] post;
        run_access(1'b1, 1'b0, 3'b000, 32'h202, 32'h0, 32'h0080FF11, 2, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (old !== 32'hFFFFFF80 || dc !== 5 || sb !== 0 || un !== 1'b0) begin
            n_fail++; $display("FAIL lb: got ld=%h cyc=%0d stallbad=%0d unstable=%b want ffffff80 5 0 0", old, dc, sb, un);
        end
        run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h0080FF11, 0, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (old !== 32'h00000080 || dc !== 3 || ob !== 4'b1100) begin
            n_fail++; $display("FAIL lhu: got ld=%h cyc=%0d be=%b want 00000080 3 1100", old, dc, ob);
        end
        run_access(1'b1, 1'b0, 3'b001, 32'h200, 32'h0, 32'h0080FF11, 1, 2,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (old !== 32'hFFFFFF11 || dc !== 5 || er !== 1'b0) begin
            n_fail++; $display("FAIL lh: got ld=%h cyc=%0d err=%b want ffffff11 5 0", old, dc, er);
        end
        rd = 32'h5A6B7C8D;
        run_access(1'b1, 1'b1, 3'b010, 32'h204, 32'h11111111, rd, 0, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (old !== rd || owe !== 1'b0 || oa !== 32'h204) begin
            n_fail++; $display("FAIL lw_both_flags: got ld=%h we=%b addr=%h want %h 0 204", old, owe, oa, rd);
        end
        exp_ld = rd;
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk_i); #1;
        req_i = 1'b1; is_load_i = 1'b1; mem_wren_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
        @(posedge clk_i); #1;
        #4 u_if.dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        u_if.dmem_gnt_i = 1'b0;
        n_chk++;
        if (stall_o !== 1'b1 || u_if.dmem_req_o !== 1'b0 || ld_data_o !== exp_ld) begin
            n_fail++; $display("FAIL rst_wait_pre: got stall=%b req=%b ld=%h want 1 0 %h", stall_o, u_if.dmem_req_o, ld_data_o, exp_ld);
        end
        #1 rst_ni = 1'b0; req_i = 1'b0; is_load_i = 1'b0;
        #1;
        n_chk++;
        if ({u_if.dmem_req_o, u_if.dmem_we_o, u_if.dmem_addr_o, u_if.dmem_be_o, u_if.dmem_wdata_o,
             stall_o, done_o, err_o, ld_data_o} !== '0) begin
            n_fail++; $display("FAIL rst_wait_async: got addr=%h stall=%b done=%b ld=%h want all 0",
                               u_if.dmem_addr_o, stall_o, done_o, ld_data_o);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        exp_ld = '0;
        #4 u_if.dmem_rvalid_i = 1'b1; u_if.dmem_rdata_i = 32'hCAFEF00D;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (done_o !== 1'b0 || stall_o !== 1'b0 || ld_data_o !== 32'h0) begin
                n_fail++; $display("FAIL rst_wait_rvalid%0d: got done=%b stall=%b ld=%h want 0 0 0", c, done_o, stall_o, ld_data_o);
            end
            @(posedge clk_i); #1 u_if.dmem_rvalid_i = 1'b0;
            #4;
        end
    endtask

    task automatic test_misalign();
        int dc, sb, edc; bit er, rq, un, erq; logic [31:0] oa, ow, old, eld; logic [3:0] ob; logic owe; logic [2:0] post;
        run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 1,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        edc = MIS_EN ? 1 : 3;
        erq = !MIS_EN;
        eld = MIS_EN ? exp_ld : 32'h12345678;
        n_chk++;
        if (dc !== edc || er !== MIS_EN || rq !== erq || sb !== 0) begin
            n_fail++; $display("FAIL lw_misal_timing: got cyc=%0d err=%b req=%b stallbad=%0d want %0d %b %b 0",
                               dc, er, rq, sb, edc, MIS_EN, erq);
        end
        n_chk++;
        if (old !== eld || {oa, ob} !== (MIS_EN ? 36'h0 : {32'h100, 4'b1111})) begin
            n_fail++; $display("FAIL lw_misal_data: got ld=%h addr=%h be=%b want ld=%h", old, oa, ob, eld);
        end
        exp_ld = eld;
    endtask

    task automatic test_timeout();
        int dc, sb; bit er, rq, un; logic [31:0] oa, ow, old; logic [3:0] ob; logic owe; logic [2:0] post;
        run_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 0,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (dc !== TO + 1 || er !== 1'b1 || sb !== 0) begin
            n_fail++; $display("FAIL to_load: got cyc=%0d err=%b stallbad=%0d want %0d 1 0", dc, er, sb, TO + 1);
        end
        n_chk++;
        if (old !== exp_ld || post !== 3'b000) begin
            n_fail++; $display("FAIL to_load_after: got ld=%h post=%b want %h 000", old, post, exp_ld);
        end
        run_access(1'b0, 1'b1, 3'b010, 32'h44, 32'h77, 32'h0, 99, 0,
                   dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
        n_chk++;
        if (dc !== TO + 1 || er !== 1'b1 || rq !== 1'b1 || un !== 1'b0 || post !== 3'b000) begin
            n_fail++; $display("FAIL to_store: got cyc=%0d err=%b req=%b unstable=%b post=%b want %0d 1 1 0 000",
                               dc, er, rq, un, post, TO + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit ld, wr, er, rq, un, emis, eerr;
            logic [2:0] f3, post;
            logic [31:0] a, st, rd, oa, ow, old;
            logic [3:0] ob;
            logic owe;
            int g, r, dc, sb, ev, edc;
            ld = ($urandom_range(0, 1) != 0);
            wr = ld ? ($urandom_range(0, 1) != 0) : 1'b1;
            f3 = 3'($urandom_range(0, 7));
            if (!ld && f3 > 3'd3) f3 = f3 - 3'd4;
            a = $urandom; st = $urandom; rd = $urandom;
            g = (i % 9 == 8) ? 50 : $urandom_range(0, 3);
            r = (i % 7 == 6) ? 0 : $urandom_range(1, 3);
            run_access(ld, wr, f3, a, st, rd, g, r, dc, er, sb, rq, un, oa, ob, ow, owe, old, post);
            emis = m_mis(f3, a);
            ev = ld ? ((r > 0) ? 1 + g + r : 1000) : 1 + g;
            eerr = emis || ev > TO;
            edc = emis ? 1 : (ev > TO ? TO + 1 : ev + 1);
            if (ld && !eerr) exp_ld = m_ld(f3, a, rd);
            n_chk++;
            if (dc !== edc || er !== eerr || sb !== 0 || rq !== !emis || post !== 3'b000) begin
                n_fail++; $display("FAIL rnd%0d_ctrl: got cyc=%0d err=%b stallbad=%0d req=%b post=%b want %0d %b 0 %b 000",
                                   i, dc, er, sb, rq, post, edc, eerr, !emis);
            end
            n_chk++;
            if (!emis && ({oa, ob, owe, un} !== {a & 32'hFFFFFFFC, m_be(f3, a), !ld, 1'b0} ||
                          (!ld && ow !== m_wd(f3, st)))) begin
                n_fail++; $display("FAIL rnd%0d_bus: got addr=%h be=%b we=%b wd=%h unstable=%b want %h %b %b %h 0",
                                   i, oa, ob, owe, ow, un, a & 32'hFFFFFFFC, m_be(f3, a), !ld, m_wd(f3, st));
            end
            n_chk++;
            if (old !== exp_ld) begin
                n_fail++; $display("FAIL rnd%0d_ld: got %h want %h (f3=%b addr=%h rdata=%h)", i, old, exp_ld, f3, a, rd);
            end
        end
    endtask

    initial begin
        u_if.dmem_gnt_i = 1'b0; u_if.dmem_rvalid_i = 1'b0; u_if.dmem_rdata_i = '0;
        test_reset();
        test_store();
        test_load();
        test_reset_in_wait();
        test_misalign();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-stage load/store unit between the EX/ME pipeline register and the ME/WB register. It sequences one data-memory access per instruction over a req/gnt/rvalid handshake. It builds byte enables and store data and formats load data by funct3. While an access is in flight it stalls the pipeline. Its ld_data_o feeds the ME/WB ld_data input directly.

Parameters:
TIMEOUT_CYCLES, 256, maximum cycles spent in REQ+WAIT before the access is aborted with err_o; width of the counter is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  valid memory instruction present in ME stage
is_load_i  in  1  instruction is a load
mem_wren_i  in  1  instruction is a store
funct3_i  in  3  access size/sign (RV32I encoding)
addr_i  in  32  effective byte address from ALU
st_data_i  in  32  store data (rs2)
dmem_req_o  out  1  memory request valid
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word address, bits [1:0] = 0
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  lane-replicated store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  32  read data
stall_o  out  1  freeze upstream stages and hold ME/WB enable low
done_o  out  1  one-cycle pulse, access complete
err_o  out  1  one-cycle pulse with done_o on timeout (or misalign, see feature)
ld_data_o  out  32  formatted load result

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0. All outputs are 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, stall_o, done_o, err_o, ld_data_o. A later rvalid seen in IDLE is ignored.
- start = req_i & (is_load_i | mem_wren_i). If both flags are set, the access is a load.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On start, register addr, funct3, we, be and wdata, then go to REQ.
  - stall_o = start (combinational).
- REQ:
  - dmem_req_o=1. Request fields stay stable until dmem_gnt_i.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - stall_o=1.
- WAIT:
  - dmem_req_o=0, stall_o=1.
  - On dmem_rvalid_i, capture formatted data into ld_data_o and go to DONE.
  - rvalid is only legal at least one cycle after gnt.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle, then go to IDLE.
  - A new start is not accepted in DONE. Upstream sees stall_o=0, advances, and the next instruction starts from IDLE.
- Minimum latency:
  - Store: 3 cycles, start -> done (IDLE, REQ with gnt, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT with rvalid, DONE).
- Timeout:
  - The counter is cleared on entering REQ and increments in REQ and WAIT.
  - When it reaches TIMEOUT_CYCLES: drop the request, go to DONE with err_o=1, leave ld_data_o unchanged.
- Byte lane: off = addr[1:0].
- Stores:
  - SB: be = 4'b0001<<off, wdata = {4{st[7:0]}}.
  - SH: be = 4'b0011<<off, wdata = {2{st[15:0]}}.
  - SW: be = 4'b1111.
- Loads:
  - LB/LBU: select byte at off; sign-extend or zero-extend.
  - LH/LHU: select halfword at off[1]; sign-extend or zero-extend.
  - LW: full word.
- funct3 011/110/111: treated as word access.
- Misaligned access (feature disabled): addr[1:0] is masked to natural alignment (half: off[0]=0; word: off=0).
- ld_data_o holds its value until the next completed load. Stores never change it.

Optional Feature:
LSU_MISALIGN_EXC_EN:
- Defined: a misaligned start (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) issues no memory request. The FSM goes IDLE->DONE with err_o=1, done_o=1, and ld_data_o unchanged; stall_o=1 in the start cycle only.
- Undefined: low address bits are masked as described in Behaviour, and err_o asserts only on timeout.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt on first REQ cycle -> dmem_addr_o=0x100, be=1111, wdata=0xDEADBEEF, we=1; done_o pulses at cycle 3; ld_data_o unchanged.
- SB addr 0x103, data 0x000000A5 -> be=1000, wdata=0xA5A5A5A5.
- LB addr 0x202, rdata 0x0080FF11, gnt delayed 2 cycles, rvalid 1 cycle after gnt -> ld_data_o=0xFFFFFF80; stall_o high every cycle from start until DONE.
- LHU addr 0x202, same rdata -> ld_data_o=0x00000080. LH addr 0x200 -> 0xFFFFFF11.
- Load with gnt but no rvalid for TIMEOUT_CYCLES -> err_o=1 and done_o=1 in the same cycle; ld_data_o unchanged; return to IDLE.
- rst_ni low while in WAIT, then rvalid after release -> outputs 0 immediately, rvalid ignored, no done_o. With LSU_MISALIGN_EXC_EN: LW addr 0x101 -> no dmem_req_o, err_o=1 at cycle 2.
